// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper and its BCD digit adder.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ONES   = 2'd1,
        S_TENS   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT     = 4'd9;
    localparam logic [7:0] DEFAULT_MAX_SCORE = 8'h99;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal adjust; shared by the ones and tens steps.
module bcd_digit_add
    import score_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    // Binary add, then subtract ten when the result leaves the decimal range.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = (raw > {1'b0, BCD_MAX_DIGIT});
        sum  = cout ? (raw[3:0] - 4'd10) : raw[3:0];
    end

endmodule

// File: rtl/score_keeper.sv
// Two-digit BCD score accumulator with saturation, sticky sat flag and a
// high score that persists across clear.
module score_keeper
    import score_pkg::*;
#(
    parameter logic [7:0] MAX_SCORE = DEFAULT_MAX_SCORE,
    parameter logic [3:0] MAX_ADD   = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add_valid,
    input  logic [3:0] add_value,
    output logic       add_ready,
    output logic [7:0] score,
    output logic [7:0] hi_score,
    output logic       sat,
    output logic       new_high
);

    state_t     state_q, state_d;
    logic [3:0] val_q, val_d;
    logic [3:0] ones_q, ones_d;
    logic       carry_q, carry_d;
    logic [7:0] score_q, score_d;
    logic [7:0] hi_q, hi_d;
    logic       sat_q, sat_d;
    logic       new_high_q, new_high_d;

    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;

    // One adder serves both digit steps; its operands follow the FSM state.
    bcd_digit_add u_digit (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign add_ready = (state_q == S_IDLE) && !clear;
    assign score     = score_q;
    assign hi_score  = hi_q;
    assign sat       = sat_q;
    assign new_high  = new_high_q;

    // Next-state, datapath sequencing and clear handling.
    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        ones_d     = ones_q;
        carry_d    = carry_q;
        score_d    = score_q;
        hi_d       = hi_q;
        sat_d      = sat_q;
        new_high_d = 1'b0;

        if (state_q == S_TENS) begin
            add_a   = score_q[7:4];
            add_b   = 4'd0;
            add_cin = carry_q;
        end else begin
            add_a   = score_q[3:0];
            add_b   = val_q;
            add_cin = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (add_valid && add_ready) begin
                    val_d   = (add_value > MAX_ADD) ? MAX_ADD : add_value;
                    state_d = S_ONES;
                end
            end
            S_ONES: begin
                ones_d  = add_sum;
                carry_d = add_cout;
                state_d = S_TENS;
            end
            S_TENS: begin
                if (add_cout || ({add_sum, ones_q} > MAX_SCORE)) begin
                    score_d = MAX_SCORE;
                    sat_d   = 1'b1;
                end else begin
                    score_d = {add_sum, ones_q};
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (score_q > hi_q) begin
                    hi_d       = score_q;
                    new_high_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Clear discards any in-flight add but leaves the high score alone.
        if (clear) begin
            state_d    = S_IDLE;
            score_d    = '0;
            sat_d      = 1'b0;
            new_high_d = 1'b0;
            hi_d       = hi_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            val_q      <= '0;
            ones_q     <= '0;
            carry_q    <= 1'b0;
            score_q    <= '0;
            hi_q       <= '0;
            sat_q      <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            ones_q     <= ones_d;
            carry_q    <= carry_d;
            score_q    <= score_d;
            hi_q       <= hi_d;
            sat_q      <= sat_d;
            new_high_q <= new_high_d;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, corner sequences and
// randomized events against a decimal reference model.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       add_valid;
    logic [3:0] add_value;
    logic       add_ready;
    logic [7:0] score;
    logic [7:0] hi_score;
    logic       sat;
    logic       new_high;

    score_keeper #(
        .MAX_SCORE (8'h99),
        .MAX_ADD   (4'd9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .add_valid (add_valid),
        .add_value (add_value),
        .add_ready (add_ready),
        .score     (score),
        .hi_score  (hi_score),
        .sat       (sat),
        .new_high  (new_high)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model in plain decimal integers.
    int   m_score;
    int   m_hi;
    logic m_sat;

    typedef struct {
        logic [3:0] value;
        logic [7:0] exp_score;
        logic       exp_sat;
        logic [7:0] exp_hi;
        logic       exp_nh;
    } vec_t;

    vec_t tbl[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    // Reset is asserted together with clear to show rst takes precedence.
    task automatic do_reset();
        rst = 1'b1; clear = 1'b1; add_valid = 1'b0; add_value = 4'd0;
        tick();
        tick();
        rst = 1'b0; clear = 1'b0;
        #1;
        chk("rst_score", score, 8'h00);
        chk("rst_hi", hi_score, 8'h00);
        chk("rst_sat", {7'b0, sat}, 8'h00);
        chk("rst_new_high", {7'b0, new_high}, 8'h00);
        chk("rst_ready", {7'b0, add_ready}, 8'h01);
        m_score = 0; m_hi = 0; m_sat = 1'b0;
    endtask

    // One full event from IDLE back to IDLE with per-phase checks.
    task automatic add_event(input logic [3:0] v, input logic [7:0] old_s,
                             input logic [7:0] exp_s, input logic exp_sat,
                             input logic [7:0] exp_hi, input logic exp_nh);
        chk("ready_idle", {7'b0, add_ready}, 8'h01);
        add_valid = 1'b1; add_value = v;
        tick();
        add_valid = 1'b0;
        chk("ready_busy", {7'b0, add_ready}, 8'h00);
        tick();
        chk("score_before_tens", score, old_s);
        tick();
        chk("score", score, exp_s);
        chk("sat", {7'b0, sat}, {7'b0, exp_sat});
        tick();
        chk("hi_score", hi_score, exp_hi);
        chk("new_high", {7'b0, new_high}, {7'b0, exp_nh});
        chk("ready_back", {7'b0, add_ready}, 8'h01);
        tick();
        chk("new_high_off", {7'b0, new_high}, 8'h00);
    endtask

    task automatic model_event(input logic [3:0] v);
        int c;
        int old;
        int s;
        logic nh;
        c   = (int'(v) > 9) ? 9 : int'(v);
        old = m_score;
        s   = m_score + c;
        if (s > 99) begin
            s = 99;
            m_sat = 1'b1;
        end
        m_score = s;
        nh = (s > m_hi);
        if (nh) m_hi = s;
        add_event(v, to_bcd(old), to_bcd(s), m_sat, to_bcd(m_hi), nh);
    endtask

    task automatic model_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        m_score = 0; m_sat = 1'b0;
        chk("clr_score", score, 8'h00);
        chk("clr_sat", {7'b0, sat}, 8'h00);
        chk("clr_hi", hi_score, to_bcd(m_hi));
        chk("clr_ready", {7'b0, add_ready}, 8'h01);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int idx;
        int cyc;
        int acc_at[3];
        logic acc;
        logic [3:0] vals[3];

        tbl[0]  = '{4'd5,  8'h05, 1'b0, 8'h05, 1'b1};
        tbl[1]  = '{4'd0,  8'h05, 1'b0, 8'h05, 1'b0};
        tbl[2]  = '{4'd9,  8'h14, 1'b0, 8'h14, 1'b1};
        tbl[3]  = '{4'd9,  8'h23, 1'b0, 8'h23, 1'b1};
        tbl[4]  = '{4'd9,  8'h32, 1'b0, 8'h32, 1'b1};
        tbl[5]  = '{4'd6,  8'h38, 1'b0, 8'h38, 1'b1};
        tbl[6]  = '{4'd7,  8'h45, 1'b0, 8'h45, 1'b1};
        tbl[7]  = '{4'd9,  8'h54, 1'b0, 8'h54, 1'b1};
        tbl[8]  = '{4'd9,  8'h63, 1'b0, 8'h63, 1'b1};
        tbl[9]  = '{4'd9,  8'h72, 1'b0, 8'h72, 1'b1};
        tbl[10] = '{4'd9,  8'h81, 1'b0, 8'h81, 1'b1};
        tbl[11] = '{4'd9,  8'h90, 1'b0, 8'h90, 1'b1};
        tbl[12] = '{4'd5,  8'h95, 1'b0, 8'h95, 1'b1};
        tbl[13] = '{4'd9,  8'h99, 1'b1, 8'h99, 1'b1};
        tbl[14] = '{4'd15, 8'h99, 1'b1, 8'h99, 1'b0};
        tbl[15] = '{4'd12, 8'h99, 1'b1, 8'h99, 1'b0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            add_event(tbl[i].value, (i == 0) ? 8'h00 : tbl[i-1].exp_score,
                      tbl[i].exp_score, tbl[i].exp_sat, tbl[i].exp_hi, tbl[i].exp_nh);
        end

        // Clear after saturation, with a simultaneous event that must be refused.
        clear = 1'b1; add_valid = 1'b1; add_value = 4'd3;
        #1;
        chk("clear_blocks_ready", {7'b0, add_ready}, 8'h00);
        tick();
        clear = 1'b0; add_valid = 1'b0;
        #1;
        chk("clear_score", score, 8'h00);
        chk("clear_sat", {7'b0, sat}, 8'h00);
        chk("clear_keeps_hi", hi_score, 8'h99);
        chk("clear_ready", {7'b0, add_ready}, 8'h01);
        tick(); tick(); tick();
        chk("clear_event_dropped", score, 8'h00);
        m_score = 0; m_hi = 99; m_sat = 1'b0;
        model_event(4'd3);

        // Clear arriving while the add sits in TENS.
        do_reset();
        model_event(4'd9);
        model_event(4'd1);
        add_valid = 1'b1; add_value = 4'd4;
        tick();
        add_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("midclr_score", score, 8'h00);
        chk("midclr_ready", {7'b0, add_ready}, 8'h01);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midclr_no_write", score, 8'h00);
            chk("midclr_no_pulse", {7'b0, new_high}, 8'h00);
        end
        chk("midclr_hi", hi_score, 8'h10);

        // Carry with add_valid held through the busy window.
        do_reset();
        model_event(4'd9);
        model_event(4'd9);
        model_event(4'd9);
        model_event(4'd9);
        model_event(4'd2);
        add_valid = 1'b1; add_value = 4'd7;
        tick();
        busy = 0;
        while (!add_ready && busy < 10) begin
            busy++;
            tick();
        end
        add_valid = 1'b0;
        chk("busy_cycles", 8'(busy), 8'd3);
        chk("carry_score", score, 8'h45);
        chk("carry_hi", hi_score, 8'h45);
        tick(); tick(); tick();
        chk("carry_single_add", score, 8'h45);

        // Back-to-back stream of 1, 2, 3 with add_valid held.
        do_reset();
        vals[0] = 4'd1; vals[1] = 4'd2; vals[2] = 4'd3;
        idx = 0; cyc = 0;
        add_valid = 1'b1; add_value = vals[0];
        while (idx < 3 && cyc < 40) begin
            acc = add_valid && add_ready;
            tick();
            if (acc) begin
                acc_at[idx] = cyc;
                idx++;
                if (idx < 3) add_value = vals[idx];
                else add_valid = 1'b0;
            end
            cyc++;
        end
        add_valid = 1'b0;
        chk("b2b_accepts", 8'(idx), 8'd3);
        if (idx == 3) begin
            chk("b2b_gap1", 8'(acc_at[1] - acc_at[0]), 8'd4);
            chk("b2b_gap2", 8'(acc_at[2] - acc_at[1]), 8'd4);
        end
        while (cyc < 12) begin
            tick();
            cyc++;
        end
        m_score = int'(vals[0]) + int'(vals[1]) + int'(vals[2]);
        m_hi = m_score;
        chk("b2b_score", score, to_bcd(m_score));
        chk("b2b_hi", hi_score, to_bcd(m_hi));

        // Randomized events and clears against the reference model.
        do_reset();
        repeat (150) begin
            if ($urandom_range(0, 9) == 0) begin
                model_clear();
            end else begin
                repeat ($urandom_range(0, 2)) tick();
                model_event(4'($urandom_range(0, 15)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
